// File: rtl/batch_vec_packer_pkg.sv
// Shared definitions for the feature-stream packer and the batch-norm stage.
// Frame geometry, sample/frame types and the hold-register state encoding.
package batch_pkg;

    localparam int N     = 32;
    localparam int W     = 16;
    localparam int IDX_W = $clog2(N);

    typedef logic signed [W-1:0] sample_t;
    typedef sample_t [0:N-1]     vec_t;

    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } hold_state_e;

    // The completing sample never lands in the assembly buffer in time, so it is spliced in here.
    function automatic vec_t load_frame(input vec_t assembly, input sample_t tail);
        vec_t frame;
        frame        = assembly;
        frame[N-1]   = tail;
        return frame;
    endfunction

endpackage

// File: rtl/batch_vec_packer_if.sv
// Sample stream in, parallel frame out. The master side feeds samples and
// acts as the frame consumer; the slave side is the packer.
interface batch_vec_packer_if;
    import batch_pkg::*;

    logic    s_valid;
    sample_t s_data;
    logic    s_last;
    logic    s_ready;
    logic    ready_in;
    logic    valid_out;
    vec_t    output_data;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        output ready_in,
        input  s_ready,
        input  valid_out,
        input  output_data
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        input  ready_in,
        output s_ready,
        output valid_out,
        output output_data
    );

endinterface

// File: rtl/batch_vec_packer.sv
// Serial-to-vector packer: assembles N samples into a frame and parks it in a
// hold register so the next frame can assemble while the consumer is busy.
module batch_vec_packer
    import batch_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    batch_vec_packer_if.slave   bus,
    output logic                frame_err_o,
    output logic [15:0]         frame_cnt_o
);

    logic [IDX_W-1:0] idx_q, idx_d;
    vec_t             asm_q, asm_d;
    vec_t             hold_q, hold_d;
    hold_state_e      state_q, state_d;
    logic             frame_err_q, frame_err_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;

    logic last_slot;
    logic full;
    logic s_ready;
    logic accept;
    logic complete;
    logic short_drop;
    logic xfer;

    assign last_slot  = (idx_q == IDX_W'(N-1));
    assign full       = (state_q == HOLD_FULL);
    // A frame may only complete when the hold register is free or draining this cycle.
    assign s_ready    = !(last_slot && full && !bus.ready_in);
    assign accept     = bus.s_valid && s_ready;
    assign complete   = accept && last_slot;
    assign short_drop = accept && bus.s_last && !last_slot;
    assign xfer       = full && bus.ready_in;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slot
            assign asm_d[gi] = (accept && (idx_q == IDX_W'(gi))) ? bus.s_data : asm_q[gi];
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        idx_d       = idx_q;
        frame_err_d = 1'b0;
        frame_cnt_d = frame_cnt_q;

        if (accept) begin
            idx_d = (last_slot || bus.s_last) ? '0 : idx_q + IDX_W'(1);
        end
        if (short_drop) begin
            frame_err_d = 1'b1;
        end
        if (xfer) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end

        case (state_q)
            HOLD_EMPTY: begin
                if (complete) begin
                    state_d = HOLD_FULL;
                    hold_d  = load_frame(asm_q, bus.s_data);
                end
            end
            HOLD_FULL: begin
                if (complete) begin
                    hold_d = load_frame(asm_q, bus.s_data);
                end else if (xfer) begin
                    state_d = HOLD_EMPTY;
                end
            end
            default: begin
                state_d = HOLD_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HOLD_EMPTY;
            idx_q       <= '0;
            asm_q       <= '0;
            hold_q      <= '0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            asm_q       <= asm_d;
            hold_q      <= hold_d;
            frame_err_q <= frame_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.s_ready     = s_ready;
    assign bus.valid_out   = full;
    assign bus.output_data = hold_q;
    assign frame_err_o     = frame_err_q;
    assign frame_cnt_o     = frame_cnt_q;

endmodule

// File: tb/tb_batch_vec_packer.sv
// Directed bench for batch_vec_packer: stimulus pushes expected frames into a
// queue, a monitor pops and compares them on every frame transfer.
module tb_batch_vec_packer;
    import batch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_err;
    logic [15:0] frame_cnt;

    batch_vec_packer_if bus();

    batch_vec_packer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .frame_err_o (frame_err),
        .frame_cnt_o (frame_cnt)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   err_seen = 0;
    int   mon_cnt = 0;
    int   stalls = 0;
    vec_t exp_q[$];
    int   xfer_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Monitor: samples just after the falling edge, when stimulus has settled.
    initial begin : monitor
        vec_t e;
        int   first_bad;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                mon_cnt = 0;
            end else begin
                if (frame_err === 1'b1) err_seen++;
                if (bus.valid_out === 1'b1 && bus.ready_in === 1'b1) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_frame: got frame with elem0=%0d required no frame",
                                 bus.output_data[0]);
                    end else begin
                        e = exp_q.pop_front();
                        first_bad = -1;
                        for (int i = 0; i < N; i++)
                            if (bus.output_data[i] !== e[i] && first_bad < 0) first_bad = i;
                        if (first_bad >= 0) begin
                            bad++;
                            $display("FAIL frame_data[%0d]: got %0d required %0d", first_bad,
                                     bus.output_data[first_bad], e[first_bad]);
                        end else begin
                            $display("ok   frame %0d transferred: elem0=%0d elem1=%0d elem31=%0d",
                                     mon_cnt, e[0], e[1], e[N-1]);
                        end
                        check("frame_cnt_at_xfer", 32'(frame_cnt), 32'(mon_cnt));
                        mon_cnt++;
                        xfer_cyc.push_back(cyc);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "timeout");
    end

    task automatic send(input sample_t d, input logic last);
        int budget;
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        #1;
        budget = 0;
        while (bus.s_ready !== 1'b1) begin
            stalls++;
            budget++;
            if (budget > 200) begin
                total++;
                bad++;
                $display("FAIL send_timeout: got s_ready=%0b required 1", bus.s_ready);
                break;
            end
            @(negedge clk);
            #1;
        end
        @(posedge clk);
    endtask

    task automatic send_frame(input vec_t f, input int n, input logic mark_last);
        for (int i = 0; i < n; i++) begin
            if (n == N && i == N-1) exp_q.push_back(f);
            send(f[i], mark_last && (i == n-1));
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    vec_t f1, f2, fa, fb, fs, f4, f5, f6, fk;
    int   n;

    initial begin : stim
        f1[0] = 16'sd8644; f1[1] = -16'sd199; f1[2] = 16'sd5674;
        for (int i = 3; i < 30; i++) f1[i] = sample_t'(i * 731 - 9000);
        f1[30] = 16'sd4998; f1[31] = 16'sd3042;
        for (int i = 0; i < N; i++) begin
            f2[i] = (i % 2 == 0) ? sample_t'(-32768) : sample_t'(32767);
            fa[i] = sample_t'(100 + i);
            fb[i] = sample_t'(-200 - i * 3);
            fs[i] = sample_t'(7000 + i);
            f4[i] = sample_t'(i * 1013 - 16000);
            f5[i] = sample_t'(555 + i);
            f6[i] = sample_t'(1234 - i * 17);
        end

        bus.s_valid  = 1'b0;
        bus.s_data   = '0;
        bus.s_last   = 1'b0;
        bus.ready_in = 1'b1;
        #1;
        check("rst_valid_out", 32'(bus.valid_out), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_data_zero", 32'(bus.output_data === '0), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_s_ready", 32'(bus.s_ready), 32'd1);

        // Basic frame with one-cycle valid pulse
        send_frame(f1, N, 1'b1);
        idle();
        #1;
        check("f1_valid_latency", 32'(bus.valid_out), 32'd1);
        @(negedge clk);
        #1;
        check("f1_valid_pulse_end", 32'(bus.valid_out), 32'd0);
        check("f1_frame_cnt", 32'(frame_cnt), 32'd1);

        // Signed extremes
        send_frame(f2, N, 1'b1);
        idle();
        repeat (2) @(negedge clk);
        #1;
        check("f2_frame_cnt", 32'(frame_cnt), 32'd2);

        // Backpressure: frame A held while frame B stalls at its last slot
        bus.ready_in = 1'b0;
        send_frame(fa, N, 1'b1);
        send_frame(fb, N-1, 1'b0);
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = fb[N-1];
        bus.s_last  = 1'b1;
        #1;
        check("bp_s_ready_low", 32'(bus.s_ready), 32'd0);
        check("bp_valid_held", 32'(bus.valid_out), 32'd1);
        repeat (3) begin
            @(negedge clk);
            #1;
            check("bp_stall_s_ready", 32'(bus.s_ready), 32'd0);
            check("bp_hold_stable0", 32'(bus.output_data[0]), 32'(fa[0]));
            check("bp_hold_stable31", 32'(bus.output_data[N-1]), 32'(fa[N-1]));
        end
        exp_q.push_back(fb);
        bus.ready_in = 1'b1;
        #0.5;
        check("bp_s_ready_rise", 32'(bus.s_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        #1;
        check("bp_valid_stays", 32'(bus.valid_out), 32'd1);
        check("bp_frame_cnt", 32'(frame_cnt), 32'd3);
        @(negedge clk);
        #1;
        check("bp_drained", 32'(bus.valid_out), 32'd0);
        check("bp_frame_cnt2", 32'(frame_cnt), 32'd4);

        // Short frame dropped, then a clean frame
        send_frame(fs, 10, 1'b1);
        idle();
        repeat (2) @(negedge clk);
        #3;
        check("short_err_count", 32'(err_seen), 32'd1);
        check("short_no_valid", 32'(bus.valid_out), 32'd0);
        send_frame(f4, N, 1'b1);
        idle();
        repeat (2) @(negedge clk);
        #1;
        check("short_next_cnt", 32'(frame_cnt), 32'd5);

        // Reset in the middle of a frame
        send_frame(f5, 20, 1'b0);
        @(negedge clk);
        bus.s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.valid_out), 32'd0);
        check("mid_rst_cnt", 32'(frame_cnt), 32'd0);
        check("mid_rst_err", 32'(frame_err), 32'd0);
        check("mid_rst_data_zero", 32'(bus.output_data === '0), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rst_s_ready", 32'(bus.s_ready), 32'd1);
        send_frame(f6, N, 1'b1);
        idle();
        repeat (2) @(negedge clk);
        #1;
        check("post_rst_cnt", 32'(frame_cnt), 32'd1);

        // Four frames back to back at full rate
        stalls = 0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < N; i++) fk[i] = sample_t'(k * 1000 + i * 37 - 500);
            send_frame(fk, N, (k % 2) == 0);
        end
        idle();
        repeat (3) @(negedge clk);
        #3;
        check("b2b_no_stalls", 32'(stalls), 32'd0);
        check("b2b_frame_cnt", 32'(frame_cnt), 32'd5);
        n = xfer_cyc.size();
        if (n >= 4) begin
            for (int j = 1; j < 4; j++)
                check("b2b_spacing", 32'(xfer_cyc[n-4+j] - xfer_cyc[n-5+j]), 32'd32);
        end else begin
            check("b2b_xfer_count", 32'(n), 32'd4);
        end

        repeat (4) @(negedge clk);
        #3;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("total_err_pulses", 32'(err_seen), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
